lane_deskew: RTL and testbench

LANE_DESKEW -- requirements
Module: lane_deskew

---
 rtl/lane_deskew.sv | 169 ++++++++++++++++
 tb/tb_lane_deskew.sv | 167 ++++++++++++++++
 2 files changed

// File: rtl/lane_deskew.sv
// Two-lane byte deskew: each lane hunts for SYNC_BYTE, buffers from the marker on, and pairs are popped once both lanes lock.
// Optional LANE_DESKEW_REALIGN_EN: a popped pair with a marker on only one lane forces a resync.

module lane_deskew_fifo #(
  parameter int DEPTH = 8
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       flush,
  input  logic       wr,
  input  logic [7:0] din,
  input  logic       rd,
  output logic [7:0] dout,
  output logic       empty,
  output logic       full,
  output logic       last_slot
);
  localparam int AW = $clog2(DEPTH);

  logic [7:0]  mem [DEPTH];
  logic [AW:0] wr_ptr, rd_ptr, level;
  logic        do_wr, do_rd;

  assign level     = wr_ptr - rd_ptr;
  assign empty     = (wr_ptr == rd_ptr);
  assign full      = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign last_slot = (level == (AW+1)'(DEPTH-1));
  assign dout      = mem[rd_ptr[AW-1:0]];
  // A pop frees the slot in the same cycle, so write-on-full with a pop is legal.
  assign do_wr     = wr && (!full || rd);
  assign do_rd     = rd && !empty;

  always_ff @(posedge clk) begin
    if (rst || flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_wr) wr_ptr <= wr_ptr + 1'b1;
      if (do_rd) rd_ptr <= rd_ptr + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (do_wr && !flush && !rst) mem[wr_ptr[AW-1:0]] <= din;
  end
endmodule

module lane_deskew #(
  parameter logic [7:0] SYNC_BYTE = 8'hBC,
  parameter int         DEPTH     = 8
) (
  input  logic       fsm_clk,
  input  logic       rst,
  input  logic       deskew_en,
  input  logic [7:0] lane_0_in,
  input  logic       lane_0_in_vld,
  input  logic [7:0] lane_1_in,
  input  logic       lane_1_in_vld,
  output logic [7:0] lane_0_rx,
  output logic [7:0] lane_1_rx,
  output logic       lane_rx_on,
  output logic       rx_vld,
  output logic       skew_err
);
  localparam int NUM_LANES = 2;

  typedef enum logic [1:0] {IDLE, SEARCH, ALIGNED} state_t;

  state_t                          state, state_nxt;
  logic [NUM_LANES-1:0][7:0]       din, dout;
  logic [NUM_LANES-1:0]            vld, is_mark, lock, lock_nxt, wr;
  logic [NUM_LANES-1:0]            empty, full, last_slot;
  logic                            pop, flush, err, pair_vld;

  assign din = {lane_1_in, lane_0_in};
  assign vld = {lane_1_in_vld, lane_0_in_vld};

  for (genvar g = 0; g < NUM_LANES; g++) begin : g_lane
    assign is_mark[g] = vld[g] && (din[g] == SYNC_BYTE);

    lane_deskew_fifo #(.DEPTH(DEPTH)) u_fifo (
      .clk       (fsm_clk),
      .rst       (rst),
      .flush     (flush),
      .wr        (wr[g]),
      .din       (din[g]),
      .rd        (pop),
      .dout      (dout[g]),
      .empty     (empty[g]),
      .full      (full[g]),
      .last_slot (last_slot[g])
    );
  end

  always_comb begin
    state_nxt = state;
    lock_nxt  = lock;
    wr        = '0;
    pop       = 1'b0;
    flush     = 1'b0;
    err       = 1'b0;
    pair_vld  = 1'b0;
    if (!deskew_en) begin
      state_nxt = IDLE;
      lock_nxt  = '0;
      flush     = 1'b1;
    end else begin
      case (state)
        IDLE: state_nxt = SEARCH;
        SEARCH: begin
          for (int i = 0; i < NUM_LANES; i++) begin
            if (vld[i] && (lock[i] || is_mark[i])) begin
              wr[i]       = 1'b1;
              lock_nxt[i] = 1'b1;
            end
          end
          if (&lock_nxt) begin
            state_nxt = ALIGNED;
          end else begin
            // Only a locked lane writes here, so the other lane is still hunting.
            for (int i = 0; i < NUM_LANES; i++)
              if (wr[i] && last_slot[i]) err = 1'b1;
          end
        end
        ALIGNED: begin
          wr       = vld;
          pop      = ~|empty;
          pair_vld = pop;
          for (int i = 0; i < NUM_LANES; i++)
            if (wr[i] && full[i] && !pop) err = 1'b1;
`ifdef LANE_DESKEW_REALIGN_EN
          if (pop && ((dout[0] == SYNC_BYTE) != (dout[1] == SYNC_BYTE))) begin
            err      = 1'b1;
            pair_vld = 1'b0;
          end
`endif
        end
        default: state_nxt = IDLE;
      endcase
      if (err) begin
        state_nxt = SEARCH;
        lock_nxt  = '0;
        flush     = 1'b1;
      end
    end
  end

  always_ff @(posedge fsm_clk) begin
    if (rst) begin
      state     <= IDLE;
      lock      <= '0;
      lane_0_rx <= 8'h00;
      lane_1_rx <= 8'h00;
      rx_vld    <= 1'b0;
      skew_err  <= 1'b0;
    end else begin
      state    <= state_nxt;
      lock     <= lock_nxt;
      rx_vld   <= pair_vld;
      skew_err <= err;
      if (pair_vld) begin
        lane_0_rx <= dout[0];
        lane_1_rx <= dout[1];
      end
    end
  end

  assign lane_rx_on = (state == ALIGNED);
endmodule

// File: tb/tb_lane_deskew.sv
// Directed bench for lane_deskew: alignment, skewed lock, search/aligned overflow, reset flush, one-sided marker pop.
module tb_lane_deskew;
  logic       clk = 1'b0;
  logic       rst, deskew_en;
  logic [7:0] lane_0_in, lane_1_in;
  logic       lane_0_in_vld, lane_1_in_vld;
  logic [7:0] lane_0_rx, lane_1_rx;
  logic       lane_rx_on, rx_vld, skew_err;
  int         total = 0;
  int         bad   = 0;

  lane_deskew dut (
    .fsm_clk       (clk),
    .rst           (rst),
    .deskew_en     (deskew_en),
    .lane_0_in     (lane_0_in),
    .lane_0_in_vld (lane_0_in_vld),
    .lane_1_in     (lane_1_in),
    .lane_1_in_vld (lane_1_in_vld),
    .lane_0_rx     (lane_0_rx),
    .lane_1_rx     (lane_1_rx),
    .lane_rx_on    (lane_rx_on),
    .rx_vld        (rx_vld),
    .skew_err      (skew_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [15:0] got, input logic [15:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", tag, got, exp);
    end
  endtask

  task automatic drv(input logic v0, input logic [7:0] d0, input logic v1, input logic [7:0] d1);
    lane_0_in_vld = v0; lane_0_in = d0;
    lane_1_in_vld = v1; lane_1_in = d1;
  endtask

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  // Checks the visible pair output after an edge.
  task automatic chk_rx(input string tag, input logic v, input logic [7:0] d0, input logic [7:0] d1);
    chk({tag, ".vld"}, {15'd0, rx_vld}, {15'd0, v});
    chk({tag, ".dat"}, {lane_0_rx, lane_1_rx}, {d0, d1});
  endtask

  initial begin
    rst = 1'b1; deskew_en = 1'b0;
    drv(0, 8'h00, 0, 8'h00);
    step;
    chk_rx("rst_out", 0, 8'h00, 8'h00);
    chk("rst_on", {15'd0, lane_rx_on}, 16'd0);
    chk("rst_err", {15'd0, skew_err}, 16'd0);

    // Same-cycle markers: pairs emerge two cycles after the marker cycle.
    rst = 1'b0; deskew_en = 1'b1;
    step;
    drv(1, 8'h55, 1, 8'h55); step;
    chk("t1_search", {15'd0, lane_rx_on}, 16'd0);
    drv(1, 8'hBC, 1, 8'hBC); step;
    chk("t1_on", {15'd0, lane_rx_on}, 16'd1);
    chk("t1_novld", {15'd0, rx_vld}, 16'd0);
    drv(1, 8'h01, 1, 8'h01); step;
    chk_rx("t1_p0", 1, 8'hBC, 8'hBC);
    drv(1, 8'h02, 1, 8'h02); step;
    chk_rx("t1_p1", 1, 8'h01, 8'h01);
    drv(0, 8'h00, 0, 8'h00); step;
    chk_rx("t1_p2", 1, 8'h02, 8'h02);
    step;
    chk_rx("t1_hold", 0, 8'h02, 8'h02);
    deskew_en = 1'b0; step;
    chk("t1_idle", {15'd0, lane_rx_on}, 16'd0);

    // Lane 1 marker arrives three cycles after lane 0.
    deskew_en = 1'b1; step;
    drv(1, 8'hBC, 1, 8'h11); step;
    drv(1, 8'h01, 1, 8'h22); step;
    drv(1, 8'h02, 1, 8'h33); step;
    chk("t2_wait", {15'd0, lane_rx_on}, 16'd0);
    drv(1, 8'h03, 1, 8'hBC); step;
    chk("t2_on", {15'd0, lane_rx_on}, 16'd1);
    drv(1, 8'h04, 1, 8'h01); step;
    chk_rx("t2_p0", 1, 8'hBC, 8'hBC);
    drv(1, 8'h05, 1, 8'h02); step;
    chk_rx("t2_p1", 1, 8'h01, 8'h01);
    chk("t2_err", {15'd0, skew_err}, 16'd0);
    drv(0, 8'h00, 0, 8'h00);
    deskew_en = 1'b0; step;

    // Lane 1 silent: 8th lane-0 write in SEARCH trips skew_err.
    deskew_en = 1'b1; step;
    for (int i = 0; i < 8; i++) begin
      drv(1, (i == 0) ? 8'hBC : 8'(i), 0, 8'h00);
      step;
      if (i == 6) chk("t3_pre", {15'd0, skew_err}, 16'd0);
    end
    chk("t3_err", {15'd0, skew_err}, 16'd1);
    chk("t3_on", {15'd0, lane_rx_on}, 16'd0);
    drv(0, 8'h00, 0, 8'h00); step;
    chk("t3_pulse", {15'd0, skew_err}, 16'd0);
    // Lane 0 lock must have been cleared by the error.
    drv(1, 8'h08, 1, 8'hBC); step;
    chk("t3_relock", {15'd0, lane_rx_on}, 16'd0);
    drv(1, 8'hBC, 0, 8'h00); step;
    chk("t3_align", {15'd0, lane_rx_on}, 16'd1);

    // ALIGNED overflow: lane 1 stalls while lane 0 writes 9 bytes.
    for (int i = 1; i <= 9; i++) begin
      drv(1, 8'hA0 + 8'(i), 0, 8'h00);
      step;
      if (i == 1) chk_rx("t4_p0", 1, 8'hBC, 8'hBC);
      if (i == 8) begin
        chk("t4_pre_err", {15'd0, skew_err}, 16'd0);
        chk("t4_pre_on", {15'd0, lane_rx_on}, 16'd1);
      end
    end
    chk("t4_err", {15'd0, skew_err}, 16'd1);
    chk("t4_on", {15'd0, lane_rx_on}, 16'd0);
    drv(0, 8'h00, 0, 8'h00);
    deskew_en = 1'b0; step;

    // Reset while ALIGNED with bytes still buffered.
    deskew_en = 1'b1; step;
    drv(1, 8'hBC, 0, 8'h00); step;
    drv(1, 8'h01, 0, 8'h00); step;
    drv(1, 8'h02, 0, 8'h00); step;
    drv(1, 8'h03, 1, 8'hBC); step;
    chk("t5_on", {15'd0, lane_rx_on}, 16'd1);
    rst = 1'b1;
    drv(1, 8'h04, 1, 8'h01); step;
    chk_rx("t5_rst", 0, 8'h00, 8'h00);
    chk("t5_rst_on", {15'd0, lane_rx_on}, 16'd0);
    chk("t5_rst_err", {15'd0, skew_err}, 16'd0);
    rst = 1'b0;
    drv(0, 8'h00, 0, 8'h00);
    step;
    step;
    chk("t5_drain", {15'd0, rx_vld}, 16'd0);

    // Pop with a marker on lane 0 only.
    drv(1, 8'hBC, 1, 8'hBC); step;
    chk("t6_on", {15'd0, lane_rx_on}, 16'd1);
    drv(1, 8'hBC, 1, 8'h00); step;
    chk_rx("t6_p0", 1, 8'hBC, 8'hBC);
    drv(0, 8'h00, 0, 8'h00); step;
`ifdef LANE_DESKEW_REALIGN_EN
    chk("t6_err", {15'd0, skew_err}, 16'd1);
    chk("t6_vld", {15'd0, rx_vld}, 16'd0);
    chk("t6_on2", {15'd0, lane_rx_on}, 16'd0);
`else
    chk_rx("t6_p1", 1, 8'hBC, 8'h00);
    chk("t6_err", {15'd0, skew_err}, 16'd0);
    chk("t6_on2", {15'd0, lane_rx_on}, 16'd1);
`endif
    step;
    chk("t6_idle", {15'd0, rx_vld}, 16'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
